rx_channel_ddc: RTL

Receive-direction counterpart of the transmit channel in the uberClock SoC datapath. Takes real ADC samples at `sys_clk` rate and mixes them to baseband with a `cordic16` rotation by the negated NCO phase. It then decimates the I and Q products by 2^DEC_LOG2 with a CIC_N-order CIC and emits baseband X/Y samples with a one-cycle `ce_down` strobe for the CSR/DSP side.

---
 rtl/rx_channel_pkg.sv | 35 +++
 rtl/cordic16.sv | 109 ++++++++++
 rtl/rx_channel_ddc_cic.sv | 72 +++++++
 rtl/rx_channel_ddc.sv | 78 +++++++
 4 files changed

// File: rtl/rx_channel_pkg.sv
// Shared constants and helpers for the receive DDC: CIC width, phase padding, output scaling.
// Build option RX_CHANNEL_ROUND_SAT_EN selects round-half-up plus saturation in the output scaler.
package rx_channel_pkg;

    // Zero bits appended below the NCO phase to form the CORDIC phase word.
    localparam int RX_PHASE_PAD = 4;

    // CIC accumulator width: output width plus the full CIC bit growth N*log2(R).
    function automatic int rx_aw(input int ow, input int n, input int d);
        return ow + n * d;
    endfunction

    // Scales the last comb output down by the CIC gain 2^sh; the caller keeps the low ow bits.
    function automatic logic signed [63:0] rx_round_sat(input logic signed [63:0] v,
                                                        input int sh,
                                                        input int ow);
        logic signed [63:0] t;
`ifdef RX_CHANNEL_ROUND_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        t  = (v + (64'sd1 <<< (sh - 1))) >>> sh;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (t > hi) begin
            t = hi;
        end else if (t < lo) begin
            t = lo;
        end
`else
        t = (v >>> sh) & ((64'sd1 <<< ow) - 64'sd1);
`endif
        return t;
    endfunction

endpackage

// File: rtl/cordic16.sv
// Pipelined rotation-mode CORDIC: quadrant pre-rotation, NSTAGES micro-rotations, truncated output.
// Output carries CORDIC gain K~1.6468 times 2^(WW-IW-2)/2^(WW-OW); latency is NSTAGES+2 cycles.
module cordic16 #(
    parameter int IW      = 16,
    parameter int OW      = 16,
    parameter int NSTAGES = 19,
    parameter int WW      = 19,
    parameter int PW      = 23
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ce,
    input  logic signed [IW-1:0] i_xval,
    input  logic signed [IW-1:0] i_yval,
    input  logic        [PW-1:0] i_phase,
    input  logic                 i_aux,
    output logic signed [OW-1:0] o_xval,
    output logic signed [OW-1:0] o_yval,
    output logic                 o_aux
);

    localparam logic [PW-1:0] QTR_TURN  = PW'(1) << (PW - 2);
    localparam logic [PW-1:0] HALF_TURN = PW'(1) << (PW - 1);

    // atan(2^-k) as a fraction of a full turn, 32-bit; scaled to PW bits on return.
    function automatic logic [PW-1:0] stage_angle(input int k);
        logic [31:0] a;
        case (k)
            0:       a = 32'h2000_0000;
            1:       a = 32'h12e4_051d;
            2:       a = 32'h09fb_385b;
            3:       a = 32'h0511_11d4;
            4:       a = 32'h028b_0d43;
            5:       a = 32'h0145_d7e1;
            6:       a = 32'h00a2_f61e;
            7:       a = 32'h0051_7c55;
            8:       a = 32'h0028_be53;
            9:       a = 32'h0014_5f2e;
            default: a = 32'(64'd683565275 >> k);
        endcase
        return PW'(a >> (32 - PW));
    endfunction

    logic signed [WW-1:0] w_ex;
    logic signed [WW-1:0] w_ey;
    logic signed [WW-1:0] r_x   [0:NSTAGES];
    logic signed [WW-1:0] r_y   [0:NSTAGES];
    logic        [PW-1:0] r_ph  [0:NSTAGES];
    logic                 r_aux [0:NSTAGES];

    // Two sign bits of headroom absorb the CORDIC gain and the -full-scale negation.
    assign w_ex = {{(WW - IW){i_xval[IW-1]}}, i_xval} <<< (WW - IW - 2);
    assign w_ey = {{(WW - IW){i_yval[IW-1]}}, i_yval} <<< (WW - IW - 2);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k <= NSTAGES; k++) begin
                r_x[k]   <= '0;
                r_y[k]   <= '0;
                r_ph[k]  <= '0;
                r_aux[k] <= 1'b0;
            end
            o_xval <= '0;
            o_yval <= '0;
            o_aux  <= 1'b0;
        end else if (i_ce) begin
            r_aux[0] <= i_aux;
            // Fold the phase into [-45, +45] degrees with an exact 0/90/180/270 rotation.
            case (i_phase[PW-1 -: 3])
                3'b001, 3'b010: begin
                    r_x[0]  <= -w_ey;
                    r_y[0]  <= w_ex;
                    r_ph[0] <= i_phase - QTR_TURN;
                end
                3'b011, 3'b100: begin
                    r_x[0]  <= -w_ex;
                    r_y[0]  <= -w_ey;
                    r_ph[0] <= i_phase - HALF_TURN;
                end
                3'b101, 3'b110: begin
                    r_x[0]  <= w_ey;
                    r_y[0]  <= -w_ex;
                    r_ph[0] <= i_phase + QTR_TURN;
                end
                default: begin
                    r_x[0]  <= w_ex;
                    r_y[0]  <= w_ey;
                    r_ph[0] <= i_phase;
                end
            endcase
            for (int k = 0; k < NSTAGES; k++) begin
                r_aux[k+1] <= r_aux[k];
                if (r_ph[k][PW-1]) begin
                    r_x[k+1]  <= r_x[k] + (r_y[k] >>> k);
                    r_y[k+1]  <= r_y[k] - (r_x[k] >>> k);
                    r_ph[k+1] <= r_ph[k] + stage_angle(k);
                end else begin
                    r_x[k+1]  <= r_x[k] - (r_y[k] >>> k);
                    r_y[k+1]  <= r_y[k] + (r_x[k] >>> k);
                    r_ph[k+1] <= r_ph[k] - stage_angle(k);
                end
            end
            o_xval <= r_x[NSTAGES][WW-1 -: OW];
            o_yval <= r_y[NSTAGES][WW-1 -: OW];
            o_aux  <= r_aux[NSTAGES];
        end
    end

endmodule

// File: rtl/rx_channel_ddc_cic.sv
// rx_cic_decim: CIC_N-order decimate-by-2^DEC_LOG2 CIC with unity DC gain and a one-cycle o_ce.
// Build option RX_CHANNEL_ROUND_SAT_EN adds rounding and saturation to the final scaling.
module rx_cic_decim
    import rx_channel_pkg::*;
#(
    parameter int OW       = 16,
    parameter int CIC_N    = 3,
    parameter int DEC_LOG2 = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic signed [OW-1:0] i_data,
    output logic signed [OW-1:0] o_data,
    output logic                 o_ce
);

    localparam int AW = rx_aw(OW, CIC_N, DEC_LOG2);
    localparam int SH = CIC_N * DEC_LOG2;

    logic signed [AW-1:0]       r_int [0:CIC_N-1];
    logic                       r_v   [0:CIC_N-1];
    logic signed [AW-1:0]       r_d   [0:CIC_N-1];
    logic signed [AW-1:0]       w_c   [0:CIC_N];
    logic        [DEC_LOG2-1:0] r_cnt;
    logic                       w_dump;

    // Counter only moves with valid integrator output, so a gated input stretches the cadence.
    assign w_dump = r_v[CIC_N-1] && (r_cnt == '1);

    always_comb begin
        w_c[0] = r_int[CIC_N-1];
        for (int k = 1; k <= CIC_N; k++) begin
            w_c[k] = w_c[k-1] - r_d[k-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < CIC_N; k++) begin
                r_int[k] <= '0;
                r_v[k]   <= 1'b0;
                r_d[k]   <= '0;
            end
            r_cnt  <= '0;
            o_data <= '0;
            o_ce   <= 1'b0;
        end else begin
            r_v[0] <= i_valid;
            if (i_valid) begin
                r_int[0] <= r_int[0] + AW'(i_data);
            end
            for (int k = 1; k < CIC_N; k++) begin
                r_v[k] <= r_v[k-1];
                if (r_v[k-1]) begin
                    r_int[k] <= r_int[k] + r_int[k-1];
                end
            end
            if (r_v[CIC_N-1]) begin
                r_cnt <= r_cnt + DEC_LOG2'(1);
            end
            o_ce <= w_dump;
            if (w_dump) begin
                for (int k = 0; k < CIC_N; k++) begin
                    r_d[k] <= w_c[k];
                end
                o_data <= OW'(rx_round_sat(64'(w_c[CIC_N]), SH, OW));
            end
        end
    end

endmodule

// File: rtl/rx_channel_ddc.sv
// Receive DDC top: mixes real ADC samples to baseband by the negated NCO phase and decimates I/Q.
// ce_down is a one-cycle strobe; rx_channel_output_x/y change only in that cycle and hold otherwise.
module rx_channel_ddc
    import rx_channel_pkg::*;
#(
    parameter int IW       = 16,
    parameter int OW       = 16,
    parameter int NSTAGES  = 19,
    parameter int WW       = 19,
    parameter int PW_I     = 19,
    parameter int PW       = 23,
    parameter int CIC_N    = 3,
    parameter int DEC_LOG2 = 3
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [PW_I-1:0]      phase_input,
    input  logic signed [IW-1:0] rx_channel_input,
    output logic signed [OW-1:0] rx_channel_output_x,
    output logic signed [OW-1:0] rx_channel_output_y,
    output logic                 ce_down
);

    logic [PW-1:0]        w_phase;
    logic signed [OW-1:0] w_mix_x;
    logic signed [OW-1:0] w_mix_y;
    logic                 w_mix_valid;
    logic                 w_unused_ce_y;

    // Negating the padded phase rotates the spectrum down, bringing the NCO tone to DC.
    assign w_phase = PW'(0) - {phase_input, {RX_PHASE_PAD{1'b0}}};

    cordic16 #(
        .IW      (IW),
        .OW      (OW),
        .NSTAGES (NSTAGES),
        .WW      (WW),
        .PW      (PW)
    ) u_cordic (
        .i_clk   (sys_clk),
        .i_rst   (rst),
        .i_ce    (1'b1),
        .i_xval  (rx_channel_input),
        .i_yval  ('0),
        .i_phase (w_phase),
        .i_aux   (1'b1),
        .o_xval  (w_mix_x),
        .o_yval  (w_mix_y),
        .o_aux   (w_mix_valid)
    );

    rx_cic_decim #(
        .OW       (OW),
        .CIC_N    (CIC_N),
        .DEC_LOG2 (DEC_LOG2)
    ) u_cic_x (
        .i_clk   (sys_clk),
        .i_rst   (rst),
        .i_valid (w_mix_valid),
        .i_data  (w_mix_x),
        .o_data  (rx_channel_output_x),
        .o_ce    (ce_down)
    );

    rx_cic_decim #(
        .OW       (OW),
        .CIC_N    (CIC_N),
        .DEC_LOG2 (DEC_LOG2)
    ) u_cic_y (
        .i_clk   (sys_clk),
        .i_rst   (rst),
        .i_valid (w_mix_valid),
        .i_data  (w_mix_y),
        .o_data  (rx_channel_output_y),
        .o_ce    (w_unused_ce_y)
    );

endmodule
